// File: rtl/mux_pipe_n.sv
// mux_pipe_n
//   Parametrised N:1 registered selector with a one-entry valid/ready output
//   stage. Typical use is next-PC source selection in the IF stage.
//   The block accepts sel/in_data and registers input[sel] onto out_data one
//   cycle later. An out-of-range sel is dropped and raises the sticky sel_err
//   flag; it never aliases onto another input. hold_cnt counts the cycles the
//   current result has been stalled by downstream backpressure, and saturates.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides every other input
//   in_data    NUM_IN packed words; word k = in_data[k*WIDTH +: WIDTH]
//   sel        binary select, sampled on accept
//   in_valid   upstream offers sel/in_data
//   in_ready   block can accept this cycle (combinational)
//   out_data   registered selected word
//   out_valid  out_data holds a result that has not been taken yet
//   out_ready  downstream takes out_data this cycle
//   flush      discard the held result and refuse input this cycle
//   err_clr    clear sel_err (a simultaneous bad accept wins)
//   sel_err    sticky out-of-range select flag
//   hold_cnt   stall cycles of the current result, saturating
module mux_pipe_n #(
  parameter int                 WIDTH     = 32,
  parameter int                 NUM_IN    = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = 8,
  localparam int                SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic                     sel_err,
  output logic [CNT_W-1:0]         hold_cnt
);

  // One extra bit so the comparison also works when NUM_IN is a power of two.
  localparam logic [SEL_W:0]     NUM_IN_V = (SEL_W + 1)'(NUM_IN);
  localparam logic [CNT_W-1:0]   HOLD_MAX = {CNT_W{1'b1}};

  // A select is legal only when it addresses an existing input. An unknown
  // select makes the comparison unknown, which the datapath below treats as
  // illegal because the if-condition falls through to its else branch.
  function automatic logic sel_in_range(input logic [SEL_W-1:0] s);
    return ({1'b0, s} < NUM_IN_V);
  endfunction

  // Word selection by explicit compare so unused select codes yield RESET_VAL
  // rather than reading past the packed input vector.
  function automatic logic [WIDTH-1:0] pick(input logic [NUM_IN*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0]        s);
    logic [WIDTH-1:0] r;
    r = RESET_VAL;
    for (int k = 0; k < NUM_IN; k++) begin
      if (s == SEL_W'(k)) begin
        r = d[k*WIDTH +: WIDTH];
      end
    end
    return r;
  endfunction

  logic             accept;
  logic             transfer;
  logic             sel_ok;
  logic [WIDTH-1:0] sel_data;

  // The single storage slot may be refilled in the same cycle it drains.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid && out_ready;
  assign sel_ok   = sel_in_range(sel);
  assign sel_data = pick(in_data, sel);

  // Output slot: data word and its valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= RESET_VAL;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_data  <= RESET_VAL;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (sel_ok) begin
        out_data  <= sel_data;
        out_valid <= 1'b1;
      end else begin
        // Bad select: input is dropped, the old result only leaves if taken.
        out_data  <= out_data;
        out_valid <= transfer ? 1'b0 : out_valid;
      end
    end else if (transfer) begin
      out_data  <= out_data;
      out_valid <= 1'b0;
    end else begin
      out_data  <= out_data;
      out_valid <= out_valid;
    end
  end

  // Sticky out-of-range flag; a new bad accept beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (accept) begin
      if (sel_ok) begin
        sel_err <= err_clr ? 1'b0 : sel_err;
      end else begin
        sel_err <= 1'b1;
      end
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= sel_err;
    end
  end

  // Stall counter: runs only while a result waits on out_ready, never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (flush) begin
      hold_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      hold_cnt <= (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mux_pipe_n.sv
// Self-checking bench for mux_pipe_n. Two instances share one stimulus stream:
// u_dut4 with default parameters (4 inputs, 8-bit stall counter) and u_dut3
// with 3 inputs and a 2-bit stall counter, so sel=3 is legal on one and an
// error on the other. A small reference model per instance predicts every
// output from the behavioural rules.
module tb_mux_pipe_n;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, flush, err_clr;
  logic [1:0]  sel;
  logic [31:0] w [4];
  logic [127:0] in_data4;
  logic [95:0]  in_data3;

  assign in_data4 = {w[3], w[2], w[1], w[0]};
  assign in_data3 = {w[2], w[1], w[0]};

  logic        ready4, valid4, err4;
  logic [31:0] data4;
  logic [7:0]  hold4;
  logic        ready3, valid3, err3;
  logic [31:0] data3;
  logic [1:0]  hold3;

  mux_pipe_n u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .sel(sel), .in_valid(in_valid),
    .in_ready(ready4), .out_data(data4), .out_valid(valid4), .out_ready(out_ready),
    .flush(flush), .err_clr(err_clr), .sel_err(err4), .hold_cnt(hold4)
  );

  mux_pipe_n #(.WIDTH(32), .NUM_IN(3), .RESET_VAL(32'h0), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel), .in_valid(in_valid),
    .in_ready(ready3), .out_data(data3), .out_valid(valid3), .out_ready(out_ready),
    .flush(flush), .err_clr(err_clr), .sel_err(err3), .hold_cnt(hold3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, index 0 = u_dut4, 1 = u_dut3.
  bit          m_valid [2];
  logic [31:0] m_data  [2];
  bit          m_err   [2];
  int          m_hold  [2];
  int          num_in  [2] = '{4, 3};
  int          hmax    [2] = '{255, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model one clock using the inputs present at the edge.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit take, acc, bad;
      take = m_valid[i] && out_ready;
      acc  = !flush && in_valid && (!m_valid[i] || out_ready);
      bad  = acc && (int'(sel) >= num_in[i]);
      if (rst) begin
        m_valid[i] = 1'b0; m_data[i] = 32'h0; m_err[i] = 1'b0; m_hold[i] = 0;
      end else begin
        if (bad) m_err[i] = 1'b1;
        else if (err_clr) m_err[i] = 1'b0;
        if (flush) begin
          m_valid[i] = 1'b0; m_data[i] = 32'h0; m_hold[i] = 0;
        end else begin
          if (m_valid[i] && !out_ready)
            m_hold[i] = (m_hold[i] < hmax[i]) ? m_hold[i] + 1 : hmax[i];
          else
            m_hold[i] = 0;
          if (acc && !bad) begin
            m_data[i] = w[sel]; m_valid[i] = 1'b1;
          end else if (take) begin
            m_valid[i] = 1'b0;
          end
        end
      end
    end
  endtask

  // One clock: check in_ready before the edge, registered outputs after it.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      chk("in_ready4", 32'(ready4), 32'(!flush && (!m_valid[0] || out_ready)));
      chk("in_ready3", 32'(ready3), 32'(!flush && (!m_valid[1] || out_ready)));
    end
    @(posedge clk);
    model_update();
    #1;
    chk("out_valid4", 32'(valid4), 32'(m_valid[0]));
    chk("out_valid3", 32'(valid3), 32'(m_valid[1]));
    chk("out_data4",  data4, m_data[0]);
    chk("out_data3",  data3, m_data[1]);
    chk("sel_err4",   32'(err4), 32'(m_err[0]));
    chk("sel_err3",   32'(err3), 32'(m_err[1]));
    chk("hold_cnt4",  32'(hold4), 32'(m_hold[0]));
    chk("hold_cnt3",  32'(hold3), 32'(m_hold[1]));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_data[i] = 32'h0; m_err[i] = 1'b0; m_hold[i] = 0;
    end
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    rst = 1'b1; in_valid = 1'b1; sel = 2'd0; out_ready = 1'b1;
    flush = 1'b0; err_clr = 1'b0;

    // Reset held two cycles with input offered.
    step(); step();
    chk("rst_data", data4, 32'h0);
    chk("rst_valid", 32'(valid4), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("ready_after_rst", 32'(ready4), 32'h1);

    // Back-to-back selects at full throughput.
    w[1] = 32'h5555_5555; w[2] = 32'hAAAA_AAAA;
    in_valid = 1'b1; sel = 2'd1; step();
    chk("s2_first", data4, 32'h5555_5555);
    sel = 2'd2; step();
    chk("s2_second", data4, 32'hAAAA_AAAA);
    chk("s2_valid", 32'(valid4), 32'h1);
    in_valid = 1'b0; step();

    // Backpressure: 5 then 6 stall cycles, small counter saturates at 3.
    in_valid = 1'b1; sel = 2'd2; step();
    out_ready = 1'b0; sel = 2'd1;
    repeat (5) step();
    chk("s3_hold5", 32'(hold4), 32'd5);
    chk("s3_hold_sat", 32'(hold3), 32'd3);
    chk("s3_data_stable", data4, 32'hAAAA_AAAA);
    step();
    chk("s3_hold6", 32'(hold4), 32'd6);
    chk("s3_hold_sat6", 32'(hold3), 32'd3);
    out_ready = 1'b1; in_valid = 1'b0; step();
    chk("s3_hold_clr", 32'(hold4), 32'd0);

    // Out-of-range select on the 3-input instance, clear, clear vs new error.
    in_valid = 1'b1; sel = 2'd3; step();
    chk("s4_err", 32'(err3), 32'h1);
    chk("s4_data_kept", data3, 32'hAAAA_AAAA);
    in_valid = 1'b0; err_clr = 1'b1; step();
    chk("s4_clr", 32'(err3), 32'h0);
    in_valid = 1'b1; sel = 2'd3; step();
    chk("s4_clr_vs_err", 32'(err3), 32'h1);
    err_clr = 1'b0;

    // Flush during backpressure with input offered.
    sel = 2'd0; step();
    out_ready = 1'b0; step(); step();
    flush = 1'b1; sel = 2'd2; w[2] = 32'h1234_5678; step();
    chk("s5_valid", 32'(valid4), 32'h0);
    chk("s5_data", data4, 32'h0);
    flush = 1'b0; in_valid = 1'b0; step();

    // Reset while stalled with sel_err set, then normal operation again.
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd3; step();
    sel = 2'd1; step();
    out_ready = 1'b0; in_valid = 1'b0; step();
    rst = 1'b1; step();
    chk("s6_err", 32'(err3), 32'h0);
    chk("s6_valid", 32'(valid4), 32'h0);
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    w[1] = 32'h5555_5555; sel = 2'd1; step();
    chk("s6_resume", data4, 32'h5555_5555);

    // Randomized traffic including long stalls.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      rst       = ($urandom_range(0, 79) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (n % 150 > 130) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
